noc_tx_arbiter: RTL
===================

Name: noc_tx_arbiter

Overview:
- Parametrised successor to the fixed three-source tx buffer selector feeding the interdevice controller.
- Each of NUM_CH flit sources (ack, waiting-ack, forwarded, future channels) gets its own DEPTH-entry FIFO.
- Heads are arbitrated in fixed-priority or round-robin mode, with optional packet locking so multi-flit packets are never interleaved.
- Output is a registered single-flit valid/ready stream to the interdevice tx side.

Parameters:
- NUM_CH, 3: number of input channels; >=2.
- FLIT_W, 128: flit width in bits.
- DEPTH, 4: entries per channel FIFO; power of 2, >=2.
- MODE, 0: 0 = fixed priority (ch0 highest); 1 = round robin.
- PKT_LOCK, 1: 1 = hold grant on a channel from first flit to tail flit; 0 = per-flit arbitration.

Ports:
- nocclk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_flit  in  NUM_CH*FLIT_W  channel c occupies bits [c*FLIT_W +: FLIT_W].
- in_tail  in  NUM_CH  flit is last of its packet.
- in_valid  in  NUM_CH  per-channel push request.
- in_ready  out  NUM_CH  per-channel FIFO not full.
- out_flit  out  FLIT_W  granted flit.
- out_tail  out  1  tail bit of out_flit.
- out_ch  out  $clog2(NUM_CH)  source channel of out_flit.
- out_valid  out  1  output holds a flit.
- out_ready  in  1  downstream accepts.
- occupancy  out  NUM_CH*($clog2(DEPTH)+1)  per-channel entry count.
- lock_active  out  1  packet lock currently held.

Behaviour:
- Reset (async assert, sync release):
  - All FIFO counts and pointers = 0; out_valid = 0; out_flit = 0; out_tail = 0; out_ch = 0.
  - lock_active = 0; round-robin pointer = 0; in_ready = 0 while rst high.
  - Reset mid-packet discards all stored flits and the lock; the partial packet is lost, with no recovery.
- FIFO push: on an edge with in_valid[c] && in_ready[c].
  - in_ready[c] = (count[c] != DEPTH), decoded from registered count, no combinational path from out_ready.
  - A full FIFO does not accept even if a pop occurs in the same cycle.
- FIFO pop: occurs when the output register loads from channel c.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Output register:
  - Load enable = !out_valid || out_ready.
  - When enabled and a channel is eligible, load the winning head, set out_valid = 1, out_ch = winner, out_tail = head tail, and pop the winner.
  - When enabled and nothing is eligible, out_valid <= 0 and the data fields hold their previous value.
  - Latency: a flit pushed at edge t is visible on out_* after edge t+1 at the earliest; an empty FIFO never bypasses.
  - Sustained throughput is 1 flit/cycle with out_ready = 1.
- Eligibility:
  - Channel c is eligible if count[c] != 0.
  - If lock_active, only the locked channel is eligible. If it is empty, the output idles (out_valid drops after the current flit is consumed) and other channels wait.
- Arbitration:
  - MODE 0: lowest-index eligible channel wins.
  - MODE 1: first eligible channel at or after rr_ptr, scanning upward with wrap.
  - rr_ptr <= winner+1 (mod NUM_CH) when the granted flit is a tail, or on every grant if PKT_LOCK = 0. It is unchanged otherwise.
- Lock (PKT_LOCK = 1):
  - Granting a non-tail flit sets lock_active = 1 and lock_ch = winner.
  - Granting a tail flit clears the lock in the same edge.
  - A single-flit packet (tail on first flit) never sets the lock.
- With PKT_LOCK = 0: lock_active is constant 0.
- occupancy reflects registered counts, range 0..DEPTH.
- Hold rule: while out_valid && !out_ready, out_flit, out_tail and out_ch are stable and no pop occurs.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse mid-cycle; hold in_valid = 0.
  - Required: out_valid = 0, all occupancy = 0, in_ready = 3'b111 one cycle after release; all remain stable.
- Fixed priority (MODE 0, PKT_LOCK 0):
  - Stimulus: single tail flits 0xA0 on ch2, 0xB0 on ch0, 0xC0 on ch1, all pushed the same edge; out_ready = 1.
  - Required: output order B0 (ch 0), C0 (ch 1), A0 (ch 2) on consecutive cycles.
- Round robin (MODE 1):
  - Stimulus: ch0 and ch1 each hold 3 single-flit packets.
  - Required: out_ch sequence 0,1,0,1,0,1; rr_ptr wraps 2->0 when ch2 is serviced in an extended run with ch2 loaded.
- Packet lock:
  - Stimulus: ch1 sends a 3-flit packet (tail on flit 3) while ch0 (higher priority) has a flit pending after flit 1 is granted.
  - Required: all 3 ch1 flits are contiguous with lock_active = 1 until the tail; the ch0 flit follows next.
- Full / backpressure (DEPTH = 4):
  - Stimulus: out_ready = 0; push 5 flits on ch0.
  - Required: 4 accepted into the FIFO plus 1 in the output register, in_ready[0] = 0, occupancy[0] = 4, out_flit stable. Then raise out_ready: flits emerge in order and in_ready[0] rises the cycle after the first pop.
- Locked-channel starvation and reset:
  - Stimulus: ch2 sends a non-tail flit, then stalls empty while ch0 has data.
  - Required: out_valid = 0 and no ch0 grant. Asserting rst clears lock_active to 0 and occupancy to 0 immediately (asynchronously).

Source files
------------

// File: rtl/noc_tx_arbiter_if.sv
// Flit-source and tx-side signal bundle for noc_tx_arbiter.
// master = the sources and the downstream sink, slave = the arbiter.
interface noc_tx_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int FLIT_W = 128,
  parameter int DEPTH  = 4
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH*FLIT_W-1:0] in_flit;
  logic [NUM_CH-1:0]        in_tail;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic [CH_W-1:0]          out_ch;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*CNT_W-1:0]  occupancy;
  logic                     lock_active;

  modport master (
    output in_flit, in_tail, in_valid, out_ready,
    input  in_ready, out_flit, out_tail, out_ch, out_valid, occupancy, lock_active
  );
  modport slave (
    input  in_flit, in_tail, in_valid, out_ready,
    output in_ready, out_flit, out_tail, out_ch, out_valid, occupancy, lock_active
  );
endinterface

// File: rtl/noc_tx_arbiter.sv
// Per-channel flit FIFOs feeding a fixed-priority / round-robin arbiter with
// optional packet locking and a registered single-flit output stage.
module noc_tx_chan_fifo #(
  parameter int FLIT_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        push_flit,
  input  logic                     push_tail,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [FLIT_W-1:0]        head_flit,
  output logic                     head_tail,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [FLIT_W:0] mem_q [DEPTH];
  logic          push;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign push_ready = !rst && (count_q != (AW+1)'(DEPTH));
  assign push       = push_valid && push_ready;
  assign {head_tail, head_flit} = mem_q[rd_ptr_q];
  assign count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_tail, push_flit};
  end
endmodule

module noc_tx_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int FLIT_W   = 128,
  parameter int DEPTH    = 4,
  parameter int MODE     = 0,
  parameter int PKT_LOCK = 1
) (
  input  logic             nocclk,
  input  logic             rst,
  noc_tx_arbiter_if.slave  bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0][FLIT_W-1:0] head_flit;
  logic [NUM_CH-1:0][CNT_W-1:0]  count;
  logic [NUM_CH-1:0]             head_tail, pop, elig, in_ready;

  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_tail_q, out_tail_d, out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d, rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d, win;
  logic              lock_q, lock_d, any_elig, load, grant;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    noc_tx_chan_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk        (nocclk),
      .rst        (rst),
      .push_flit  (bus.in_flit[c*FLIT_W +: FLIT_W]),
      .push_tail  (bus.in_tail[c]),
      .push_valid (bus.in_valid[c]),
      .push_ready (in_ready[c]),
      .pop        (pop[c]),
      .head_flit  (head_flit[c]),
      .head_tail  (head_tail[c]),
      .count      (count[c])
    );
  end

  assign bus.in_ready    = in_ready;
  assign bus.occupancy   = count;
  assign bus.out_flit    = out_flit_q;
  assign bus.out_tail    = out_tail_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.lock_active = lock_q;

  always_comb begin
    elig     = '0;
    win      = '0;
    any_elig = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = (count[c] != '0) && (!lock_q || lock_ch_q == CH_W'(c));
    // Scan from the far end so the last hit (nearest the start point) wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int idx;
      idx = (MODE == 1) ? int'(rr_ptr_q) + k : k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (elig[idx]) begin
        win      = CH_W'(idx);
        any_elig = 1'b1;
      end
    end
  end

  assign load  = !out_valid_q || bus.out_ready;
  assign grant = load && any_elig;

  always_comb begin
    pop         = '0;
    out_flit_d  = out_flit_q;
    out_tail_d  = out_tail_q;
    out_ch_d    = out_ch_q;
    out_valid_d = load ? any_elig : out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (grant) begin
      pop[win]   = 1'b1;
      out_flit_d = head_flit[win];
      out_tail_d = head_tail[win];
      out_ch_d   = win;
      if (head_tail[win] || PKT_LOCK == 0)
        rr_ptr_d = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
      if (PKT_LOCK != 0) begin
        lock_d    = !head_tail[win];
        lock_ch_d = win;
      end
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      out_flit_q  <= '0;
      out_tail_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_flit_q  <= out_flit_d;
      out_tail_q  <= out_tail_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end
endmodule
